// File: rtl/time_set_ctrl_pkg.sv
// Shared types, limits and field arithmetic for the time-setting front end.
package time_set_pkg;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;

  localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } edit_state_e;

  // Captured live values outside the legal range start the edit from zero.
  function automatic logic [HOURS_W-1:0] clampHours(input logic [HOURS_W-1:0] h);
    return (h > HOURS_MAX) ? '0 : h;
  endfunction

  function automatic logic [MINUTES_W-1:0] clampMinutes(input logic [MINUTES_W-1:0] m);
    return (m > MINUTES_MAX) ? '0 : m;
  endfunction

  // One step up or down with wrap-around inside 0..HOURS_MAX.
  function automatic logic [HOURS_W-1:0] stepHours(input logic [HOURS_W-1:0] h, input logic up);
    if (up) return (h >= HOURS_MAX) ? '0 : h + HOURS_W'(1);
    else    return (h == '0 || h > HOURS_MAX) ? HOURS_MAX : h - HOURS_W'(1);
  endfunction

  // One step up or down with wrap-around inside 0..MINUTES_MAX.
  function automatic logic [MINUTES_W-1:0] stepMinutes(input logic [MINUTES_W-1:0] m, input logic up);
    if (up) return (m >= MINUTES_MAX) ? '0 : m + MINUTES_W'(1);
    else    return (m == '0 || m > MINUTES_MAX) ? MINUTES_MAX : m - MINUTES_W'(1);
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, live-time and edited-time signals between the board side and the
// time-setting controller. The controller uses the slave view.
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic                 btn_mode;
  logic                 btn_inc;
  logic                 btn_dec;
  logic [HOURS_W-1:0]   cur_hours;
  logic [MINUTES_W-1:0] cur_minutes;
  logic [HOURS_W-1:0]   set_hours;
  logic [MINUTES_W-1:0] set_minutes;
  logic                 load;
  logic                 editing;
  logic                 blank_hours;
  logic                 blank_minutes;

  modport master (
    output btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
    input  set_hours, set_minutes, load, editing, blank_hours, blank_minutes
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
    output set_hours, set_minutes, load, editing, blank_hours, blank_minutes
  );

endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// One raw pushbutton: two-flop synchronizer, stability counter, and a
// single-cycle pulse when a new pressed level is accepted.
// After reset the button is locked out until it has been seen released for
// DEBOUNCE_CYCLES cycles, so a button held through reset never fires.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             block_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cntDone;

  assign cntDone = (cnt_q == CNT_LAST);
  assign press_o = press_q;

  // Synchronize, then accept a level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      block_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (block_q) begin
        if (sync2_q) begin
          cnt_q <= '0;
        end else if (cntDone) begin
          cnt_q   <= '0;
          block_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (sync2_q != level_q) begin
        if (cntDone) begin
          level_q <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: conditions the three buttons, walks the
// RUN -> SET_HOUR -> SET_MIN -> COMMIT edit sequence, blinks the active
// field and abandons an edit after a long idle period.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                BLINK_W    = $clog2(BLINK_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  edit_state_e          state_q, state_d;
  logic [HOURS_W-1:0]   hours_q, hours_d;
  logic [MINUTES_W-1:0] minutes_q, minutes_d;
  logic [IDLE_W-1:0]    idleCnt_q, idleCnt_d;
  logic [BLINK_W-1:0]   blinkCnt_q, blinkCnt_d;
  logic                 phase_q, phase_d;
  logic                 modePress, incPress, decPress;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) modeBtn (
    .clk(clk), .rst(rst), .raw_i(bus.btn_mode), .press_o(modePress));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) incBtn (
    .clk(clk), .rst(rst), .raw_i(bus.btn_inc), .press_o(incPress));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) decBtn (
    .clk(clk), .rst(rst), .raw_i(bus.btn_dec), .press_o(decPress));

  // Register the edit state, the edited time and the idle/blink timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      hours_q    <= '0;
      minutes_q  <= '0;
      idleCnt_q  <= '0;
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      idleCnt_q  <= idleCnt_d;
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
    end
  end

  // Mode presses advance the edit; inc/dec edit the active field; idle time
  // drives both the blink phase and the abandon-edit timeout.
  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    idleCnt_d  = idleCnt_q;
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    case (state_q)
      RUN: begin
        idleCnt_d = '0;
        if (modePress) begin
          state_d    = SET_HOUR;
          hours_d    = clampHours(bus.cur_hours);
          minutes_d  = clampMinutes(bus.cur_minutes);
          blinkCnt_d = '0;
          phase_d    = 1'b0;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (modePress) begin
          state_d    = (state_q == SET_HOUR) ? SET_MIN : COMMIT;
          idleCnt_d  = '0;
          blinkCnt_d = '0;
          phase_d    = 1'b0;
        end else if (incPress || decPress) begin
          idleCnt_d  = '0;
          blinkCnt_d = '0;
          phase_d    = 1'b0;
          if (incPress != decPress) begin
            if (state_q == SET_HOUR) hours_d   = stepHours(hours_q, incPress);
            else                     minutes_d = stepMinutes(minutes_q, incPress);
          end
        end else if (idleCnt_q == IDLE_LAST) begin
          state_d = RUN;
        end else begin
          idleCnt_d = idleCnt_q + IDLE_W'(1);
          if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d = '0;
            phase_d    = ~phase_q;
          end else begin
            blinkCnt_d = blinkCnt_q + BLINK_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d   = RUN;
        idleCnt_d = '0;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.set_hours     = hours_q;
  assign bus.set_minutes   = minutes_q;
  assign bus.load          = (state_q == COMMIT);
  assign bus.editing       = (state_q != RUN);
  assign bus.blank_hours   = (state_q == SET_HOUR) && phase_q;
  assign bus.blank_minutes = (state_q == SET_MIN) && phase_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with short debounce/blink/timeout.
// A behavioural model predicts each accepted press from the raw edge time,
// then applies the edit rules with modular arithmetic; blink and timeout are
// derived from the time since the last accepted event.
module tb_time_set_ctrl;

  localparam int D = 4;
  localparam int B = 8;
  localparam int T = 100;

  typedef enum int {M_RUN, M_SH, M_SM, M_COMMIT} mstate_e;
  typedef struct {
    int         edgeNo;
    logic [2:0] mask;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  time_set_ctrl_if ifc();

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES(B),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  int      testCount = 0;
  int      failCount = 0;
  int      cyc = 0;
  int      lastEvt = 0;
  int      mH = 0;
  int      mM = 0;
  int      mCommits = 0;
  int      loadSeen = 0;
  bit      checkEn = 1'b0;
  mstate_e mState = M_RUN;
  evt_t    evtQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Raise the buttons in mask for hold cycles, then release for gap cycles.
  // A hold of at least D cycles is an accepted press, used by the FSM on the
  // edge 3+D after the raw edge (2 sync + D debounce + 1 registered pulse).
  task automatic applyStimulus(input logic [2:0] mask, input int hold, input int gap);
    evt_t e;
    @(negedge clk);
    {ifc.btn_mode, ifc.btn_inc, ifc.btn_dec} = mask;
    if (hold >= D) begin
      e.edgeNo = cyc + 3 + D;
      e.mask   = mask;
      evtQ.push_back(e);
    end
    repeat (hold) @(negedge clk);
    {ifc.btn_mode, ifc.btn_inc, ifc.btn_dec} = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic setCur(input int h, input int m);
    @(negedge clk);
    ifc.cur_hours   = 5'(h);
    ifc.cur_minutes = 6'(m);
  endtask

  // Reference model, advanced once per clock edge.
  always @(posedge clk) begin : model
    logic [2:0] p;
    int         ch;
    int         cm;
    cyc++;
    p = 3'b000;
    if (rst) begin
      mState  = M_RUN;
      mH      = 0;
      mM      = 0;
      lastEvt = cyc;
      evtQ.delete();
    end else begin
      while (evtQ.size() > 0 && evtQ[0].edgeNo <= cyc) begin
        p = p | evtQ[0].mask;
        void'(evtQ.pop_front());
      end
      case (mState)
        M_RUN: if (p[2]) begin
          ch = int'(ifc.cur_hours);
          cm = int'(ifc.cur_minutes);
          mH = (ch <= 23) ? ch : 0;
          mM = (cm <= 59) ? cm : 0;
          mState  = M_SH;
          lastEvt = cyc;
        end
        M_SH, M_SM: begin
          if (p[2]) begin
            if (mState == M_SH) mState = M_SM;
            else begin
              mState = M_COMMIT;
              mCommits++;
            end
            lastEvt = cyc;
          end else if (p[1] || p[0]) begin
            lastEvt = cyc;
            if (p[1] && !p[0]) begin
              if (mState == M_SH) mH = (mH + 1) % 24;
              else                mM = (mM + 1) % 60;
            end else if (p[0] && !p[1]) begin
              if (mState == M_SH) mH = (mH + 23) % 24;
              else                mM = (mM + 59) % 60;
            end
          end else if (cyc - lastEvt >= T) begin
            mState = M_RUN;
          end
        end
        default: mState = M_RUN;
      endcase
    end
  end

  // Compare every visible output against the model once per cycle.
  always @(negedge clk) begin
    bit ph;
    if (checkEn) begin
      ph = (((cyc - lastEvt) / B) % 2) == 1;
      if (ifc.load === 1'b1) loadSeen++;
      checkOutput("load", 32'(ifc.load), 32'(mState == M_COMMIT));
      checkOutput("editing", 32'(ifc.editing), 32'(mState != M_RUN));
      checkOutput("blankHours", 32'(ifc.blank_hours), 32'(mState == M_SH && ph));
      checkOutput("blankMinutes", 32'(ifc.blank_minutes), 32'(mState == M_SM && ph));
      checkOutput("setHours", 32'(ifc.set_hours), 32'(mH));
      checkOutput("setMinutes", 32'(ifc.set_minutes), 32'(mM));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ifc.btn_mode    = 1'b0;
    ifc.btn_inc     = 1'b0;
    ifc.btn_dec     = 1'b0;
    ifc.cur_hours   = 5'd0;
    ifc.cur_minutes = 6'd0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetLoad", 32'(ifc.load), 32'd0);
    checkOutput("resetEditing", 32'(ifc.editing), 32'd0);
    checkOutput("resetSetHours", 32'(ifc.set_hours), 32'd0);
    rst = 1'b0;
    repeat (D + 3) @(negedge clk);

    // Glitch rejection, then a real increment.
    setCur(10, 20);
    applyStimulus(3'b100, D + 2, D + 4);
    applyStimulus(3'b010, 3, D + 4);
    checkOutput("glitchHours", 32'(ifc.set_hours), 32'd10);
    applyStimulus(3'b010, 10, D + 4);
    checkOutput("incHours", 32'(ifc.set_hours), 32'd11);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b100, D + 1, D + 4);

    // Full edit with hours and minutes wrap.
    setCur(22, 58);
    applyStimulus(3'b100, D + 1, D + 4);
    repeat (2) applyStimulus(3'b010, D + 1, D + 4);
    applyStimulus(3'b100, D + 1, D + 4);
    repeat (3) applyStimulus(3'b010, D + 1, D + 4);
    applyStimulus(3'b100, D + 1, D + 4);
    checkOutput("editHours", 32'(ifc.set_hours), 32'd0);
    checkOutput("editMinutes", 32'(ifc.set_minutes), 32'd1);
    checkOutput("editDone", 32'(ifc.editing), 32'd0);

    // Decrement wraps in both fields, then increment back over the top.
    setCur(0, 0);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b001, D + 1, D + 4);
    checkOutput("decHoursWrap", 32'(ifc.set_hours), 32'd23);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b001, D + 1, D + 4);
    checkOutput("decMinutesWrap", 32'(ifc.set_minutes), 32'd59);
    applyStimulus(3'b010, D + 1, D + 4);
    checkOutput("incMinutesWrap", 32'(ifc.set_minutes), 32'd0);
    applyStimulus(3'b100, D + 1, D + 4);

    // Simultaneous presses.
    setCur(5, 10);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b011, D + 1, D + 4);
    checkOutput("incDecHours", 32'(ifc.set_hours), 32'd5);
    applyStimulus(3'b110, D + 1, D + 4);
    checkOutput("modeIncHours", 32'(ifc.set_hours), 32'd5);
    checkOutput("modeIncMinutes", 32'(ifc.set_minutes), 32'd10);
    checkOutput("modeIncInSetMin", 32'(ifc.blank_hours), 32'd0);
    checkOutput("modeIncEditing", 32'(ifc.editing), 32'd1);
    applyStimulus(3'b100, D + 1, D + 4);

    // Timeout from SET_MIN keeps the edited value and never loads.
    setCur(7, 30);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b100, D + 1, D + 4);
    repeat (T + 10) @(negedge clk);
    checkOutput("timeoutEditing", 32'(ifc.editing), 32'd0);
    checkOutput("timeoutHours", 32'(ifc.set_hours), 32'd7);
    checkOutput("timeoutMinutes", 32'(ifc.set_minutes), 32'd30);

    // Reset while in SET_MIN.
    setCur(12, 34);
    applyStimulus(3'b100, D + 1, D + 4);
    applyStimulus(3'b100, D + 1, D + 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidLoad", 32'(ifc.load), 32'd0);
    checkOutput("rstMidEditing", 32'(ifc.editing), 32'd0);
    checkOutput("rstMidMinutes", 32'(ifc.set_minutes), 32'd0);
    rst = 1'b0;
    repeat (D + 3) @(negedge clk);

    // Mode held through reset must not start an edit.
    @(negedge clk);
    ifc.btn_mode = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("heldModeEditing", 32'(ifc.editing), 32'd0);
    ifc.btn_mode = 1'b0;
    repeat (D + 3) @(negedge clk);
    checkOutput("heldModeReleased", 32'(ifc.editing), 32'd0);
    applyStimulus(3'b100, D + 1, D + 4);
    checkOutput("modeAfterRelease", 32'(ifc.editing), 32'd1);

    // Randomized presses, glitches, value changes and idle stretches.
    for (int i = 0; i < 80; i++) begin
      int         pick;
      int         hold;
      int         gap;
      logic [2:0] mask;
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: mask = 3'b100;
        3, 4:    mask = 3'b010;
        5, 6:    mask = 3'b001;
        7:       mask = 3'b011;
        8:       mask = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b101;
        default: mask = 3'b010;
      endcase
      hold = (pick == 9) ? int'($urandom_range(1, D - 1)) : D + int'($urandom_range(0, 4));
      gap  = D + 3 + int'($urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) gap = gap + T;
      if ($urandom_range(0, 3) == 0) begin
        ifc.cur_hours   = 5'($urandom_range(0, 31));
        ifc.cur_minutes = 6'($urandom_range(0, 63));
      end
      applyStimulus(mask, hold, gap);
    end

    repeat (T + 10) @(negedge clk);
    checkOutput("loadCount", 32'(loadSeen), 32'(mCommits));
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Input side of the digital clock: reads three raw pushbuttons and lets the user edit hours and minutes.
- Steps through an edit state machine and hands the edited time back to the timekeeping counters as a one-cycle load.
- Drives blank flags so the display multiplexer blinks the field being edited.
- Sits between the board buttons and the hours/minutes counters, on the same clk as the display logic.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- BLINK_CYCLES, 12500000: half-period of the edit-field blink, in cycles (0.25 s).
- TIMEOUT_CYCLES, 500000000: idle cycles in an edit state before the edit is abandoned (10 s).

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  synchronous reset, active-high.
- btn_mode  in  1  raw, asynchronous mode button, active-high.
- btn_inc  in  1  raw, asynchronous increment button, active-high.
- btn_dec  in  1  raw, asynchronous decrement button, active-high.
- cur_hours  in  5  live hours from the timekeeper, 0..23.
- cur_minutes  in  6  live minutes from the timekeeper, 0..59.
- set_hours  out  5  edited hours value.
- set_minutes  out  6  edited minutes value.
- load  out  1  one-cycle pulse; timekeeper copies set_* and clears seconds.
- editing  out  1  high in any edit state; timekeeper freezes counting.
- blank_hours  out  1  display blanks the hours digits while high.
- blank_minutes  out  1  display blanks the minutes digits while high.

Behaviour:
- Clock and reset: single clock domain, synchronous active-high reset.
- Values after reset:
  - state RUN; set_hours = 0, set_minutes = 0; all outputs 0.
  - debounced levels 0; counters 0; blink phase 0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized level differs from the accepted level, and clears when the two agree.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synchronized level.
  - A one-cycle press pulse fires on an accepted 0->1 transition. Release produces no pulse.
  - Latency from a clean raw edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: RUN, SET_HOUR, SET_MIN, COMMIT.
  - RUN + mode press -> SET_HOUR. On the transition, set_hours <= cur_hours and set_minutes <= cur_minutes.
  - SET_HOUR + mode press -> SET_MIN.
  - SET_MIN + mode press -> COMMIT.
  - COMMIT -> RUN unconditionally after one cycle. load = 1 only in COMMIT.
  - editing = 1 in SET_HOUR, SET_MIN and COMMIT.
- Edit arithmetic (active field only):
  - Hours: inc wraps 23->0; dec wraps 0->23.
  - Minutes: inc wraps 59->0; dec wraps 0->59.
  - No carry between fields.
  - A captured cur value out of range is clamped: hours >23 -> 0, minutes >59 -> 0.
- Simultaneous events:
  - inc and dec in the same cycle: no change to the field.
  - mode together with inc or dec: the mode transition wins and the inc/dec press is discarded.
  - inc/dec presses in RUN and COMMIT are ignored.
- Timeout:
  - The idle counter clears on any press and on entering SET_HOUR.
  - It increments in SET_HOUR and SET_MIN.
  - At TIMEOUT_CYCLES-1 the FSM goes to RUN with no load pulse; set_* keep their values.
- Blink:
  - The phase toggles every BLINK_CYCLES cycles while in SET_HOUR or SET_MIN.
  - The phase is forced to 0 (digits visible) on every accepted press and on entering an edit state.
  - blank_hours = (state==SET_HOUR) & phase.
  - blank_minutes = (state==SET_MIN) & phase.
  - Both blank flags are 0 elsewhere.
- Reset mid-edit: returns to RUN immediately, with no load pulse.

Decomposition:
- Package time_set_pkg holds:
  - the state enum (RUN, SET_HOUR, SET_MIN, COMMIT);
  - HOURS_MAX = 23 and MINUTES_MAX = 59;
  - widths HOURS_W = 5 and MINUTES_W = 6.
- Sub-module btn_debounce (synchronizer + debounce counter + press pulse, parameter DEBOUNCE_CYCLES) is instantiated once per button.
- FSM, edit arithmetic, timeout counter and blink counter live in the top module.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=100.
1. Glitch rejection: btn_inc high for 3 cycles in SET_HOUR -> no press pulse, set_hours unchanged. Held for 10 cycles -> exactly one increment, 6 cycles after the raw edge.
2. Full edit with hours wrap: cur = 22:58; press mode, inc x2, mode, inc x3, mode.
   - Expected: set = 00:01; load high for exactly one cycle; then state RUN and editing 0.
3. Decrement wraps: in SET_HOUR from 0, dec -> 23. In SET_MIN from 0, dec -> 59; then inc -> 0.
4. Simultaneous presses: inc+dec in the same cycle -> no change. Mode+inc in the same cycle in SET_HOUR -> SET_MIN entered, hours unchanged.
5. Timeout: enter SET_MIN and stay idle for 100 cycles -> state RUN, load never asserted, editing 0.
   - Blink check in that window: blank_minutes toggles every 8 cycles and blank_hours stays 0.
6. Reset in SET_MIN -> next cycle state RUN, all outputs 0, and no load. Reset with btn_mode held -> no press pulse until btn_mode is released and pressed again.
